// File: rtl/fifo_ctrl_thr_pkg.sv
// Shared types and helpers for the threshold FIFO controller.
package fifo_pkg;

  // Encoded as {wr, rd}.
  typedef enum logic [1:0] {
    OpNone  = 2'b00,
    OpRead  = 2'b01,
    OpWrite = 2'b10,
    OpBoth  = 2'b11
  } fifo_op_e;

  // Modulo-depth increment; any value at or past the last slot returns to 0.
  function automatic logic [7:0] wrap_inc(input logic [7:0] ptr, input int unsigned depth);
    if ({24'd0, ptr} >= depth - 1) return 8'd0;
    return ptr + 8'd1;
  endfunction

endpackage

// File: rtl/fifo_ctrl_thr_if.sv
// Handshake and status bundle between producer/consumer and fifo_ctrl_thr.
interface fifo_ctrl_thr_if #(
  parameter int unsigned Depth = 16
);
  localparam int unsigned AddrBits  = $clog2(Depth);
  localparam int unsigned CountBits = $clog2(Depth + 1);

  logic                 wr_i;
  logic                 rd_i;
  logic                 clr_i;
  logic                 w_en_o;
  logic [AddrBits-1:0]  w_addr_o;
  logic [AddrBits-1:0]  r_addr_o;
  logic [CountBits-1:0] count_o;
  logic                 empty_o;
  logic                 full_o;
  logic                 almost_empty_o;
  logic                 almost_full_o;
  logic                 overflow_o;
  logic                 underflow_o;

  modport master (
    output wr_i, rd_i, clr_i,
    input  w_en_o, w_addr_o, r_addr_o, count_o, empty_o, full_o,
           almost_empty_o, almost_full_o, overflow_o, underflow_o
  );

  modport slave (
    input  wr_i, rd_i, clr_i,
    output w_en_o, w_addr_o, r_addr_o, count_o, empty_o, full_o,
           almost_empty_o, almost_full_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_ctrl_thr_ptr.sv
// Modulo-Depth wrapping pointer register with increment and synchronous clear.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrBits = $clog2(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_i,
  input  logic                clr_i,
  output logic [AddrBits-1:0] ptr_o
);

  logic [AddrBits-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = AddrBits'(wrap_inc(8'(ptr_q), Depth));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl_thr.sv
// Register-file FIFO controller with arbitrary depth, thresholds and flush.
// Define FIFO_CTRL_ERR_EN to build the sticky overflow/underflow flags.
module fifo_ctrl_thr
  import fifo_pkg::*;
#(
  parameter int unsigned Depth          = 16,
  parameter int unsigned AlmostFullThr  = 14,
  parameter int unsigned AlmostEmptyThr = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  fifo_ctrl_thr_if.slave   fifo_io
);

  localparam int unsigned AddrBits  = $clog2(Depth);
  localparam int unsigned CountBits = $clog2(Depth + 1);

  logic                 clr, rd_acc, wr_acc, wr_en, rd_en;
  fifo_op_e             op;
  logic [CountBits-1:0] cnt_d, cnt_q;
  logic                 empty_q, full_q, aempty_q, afull_q;
  logic [AddrBits-1:0]  w_addr, r_addr;

  assign clr    = fifo_io.clr_i;
  assign rd_acc = fifo_io.rd_i & ~empty_q;
  // A read on a full FIFO frees the slot this write lands in.
  assign wr_acc = fifo_io.wr_i & (~full_q | fifo_io.rd_i);
  assign wr_en  = wr_acc & ~clr;
  assign rd_en  = rd_acc & ~clr;
  assign op     = fifo_op_e'({wr_en, rd_en});

  fifo_ptr #(.Depth(Depth)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (wr_en),
    .clr_i (clr),
    .ptr_o (w_addr)
  );

  fifo_ptr #(.Depth(Depth)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (rd_en),
    .clr_i (clr),
    .ptr_o (r_addr)
  );

  always_comb begin
    cnt_d = cnt_q;
    unique case (op)
      OpWrite: cnt_d = cnt_q + CountBits'(1);
      OpRead:  cnt_d = cnt_q - CountBits'(1);
      default: cnt_d = cnt_q;
    endcase
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      empty_q  <= (cnt_d == '0);
      full_q   <= (cnt_d == CountBits'(Depth));
      aempty_q <= (cnt_d <= CountBits'(AlmostEmptyThr));
      afull_q  <= (cnt_d >= CountBits'(AlmostFullThr));
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic ovf_d, ovf_q, udf_d, udf_q;

  always_comb begin
    ovf_d = ovf_q | (fifo_io.wr_i & full_q & ~fifo_io.rd_i);
    udf_d = udf_q | (fifo_io.rd_i & empty_q);
    if (clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign fifo_io.overflow_o  = ovf_q;
  assign fifo_io.underflow_o = udf_q;
`else
  assign fifo_io.overflow_o  = 1'b0;
  assign fifo_io.underflow_o = 1'b0;
`endif

  assign fifo_io.w_en_o         = wr_en;
  assign fifo_io.w_addr_o       = w_addr;
  assign fifo_io.r_addr_o       = r_addr;
  assign fifo_io.count_o        = cnt_q;
  assign fifo_io.empty_o        = empty_q;
  assign fifo_io.full_o         = full_q;
  assign fifo_io.almost_empty_o = aempty_q;
  assign fifo_io.almost_full_o  = afull_q;

endmodule
